// File: rtl/lfsr_16_checker.sv
// Receive-side checker for the x^16+x^15+x^2+1 dither LFSR: hunts for a seed, verifies, then flywheels and counts mismatches.
// Define LFSR_CHK_BITERR_EN to count bit errors (popcount) instead of word errors and to add err_bits_out.
module lfsr_16_checker #(
   parameter int LOCK_COUNT   = 8,
   parameter int UNLOCK_COUNT = 4,
   parameter int ERR_W        = 16
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             valid_in,
   input  logic [15:0]      data_in,
   input  logic             clear_in,
   output logic             locked_out,
   output logic             err_out,
   output logic             sticky_err_out,
   output logic [ERR_W-1:0] err_count_out
`ifdef LFSR_CHK_BITERR_EN
   ,
   output logic [4:0]       err_bits_out
`endif
);

   localparam int MC_W  = $clog2(LOCK_COUNT + 1);
   localparam int UC_W  = $clog2(UNLOCK_COUNT + 1);
   localparam int SUM_W = ERR_W + 6;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_W{1'b1}});

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[15] ^ q[14], q[13:2], q[15] ^ q[1], q[0], q[15]};
   endfunction

   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc, input logic [4:0] inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(acc) + SUM_W'(inc);
      return (sum > CNT_MAX) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
   endfunction

`ifdef LFSR_CHK_BITERR_EN
   function automatic logic [4:0] popcount16(input logic [15:0] x);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + 5'(x[i]);
      return n;
   endfunction
`endif

   state_t           state_p1, state_nx;
   logic [15:0]      exp_p1, exp_nx;
   logic [MC_W-1:0]  match_cnt_p1, match_nx;
   logic [UC_W-1:0]  miss_cnt_p1, miss_nx;
   logic             err_p1, err_nx;
   logic             sticky_p1;
   logic [ERR_W-1:0] cnt_p1;
   logic [4:0]       bits_p1;
   logic             vld_p0;
   logic             hit_p0;
   logic [4:0]       err_inc_p0;

   assign vld_p0 = valid_in;
   assign hit_p0 = (data_in == exp_p1);

`ifdef LFSR_CHK_BITERR_EN
   assign err_inc_p0   = popcount16(data_in ^ exp_p1);
   assign err_bits_out = bits_p1;
`else
   assign err_inc_p0 = 5'd1;
`endif

   always_comb begin
      state_nx = state_p1;
      exp_nx   = exp_p1;
      match_nx = match_cnt_p1;
      miss_nx  = miss_cnt_p1;
      err_nx   = 1'b0;
      if (vld_p0) begin
         case (state_p1)
            HUNT: begin
               // All-zero is the LFSR lock-up word and can never seed the flywheel
               if (data_in != '0) begin
                  exp_nx   = lfsr_next(data_in);
                  match_nx = '0;
                  state_nx = VERIFY;
               end
            end
            VERIFY: begin
               if (hit_p0) begin
                  exp_nx   = lfsr_next(exp_p1);
                  match_nx = match_cnt_p1 + MC_W'(1);
                  if (match_nx == MC_W'(LOCK_COUNT)) begin
                     state_nx = LOCKED;
                     miss_nx  = '0;
                  end
               end else if (data_in == '0) begin
                  match_nx = '0;
                  state_nx = HUNT;
               end else begin
                  exp_nx   = lfsr_next(data_in);
                  match_nx = '0;
               end
            end
            LOCKED: begin
               exp_nx = lfsr_next(exp_p1);
               if (hit_p0) begin
                  miss_nx = '0;
               end else begin
                  err_nx  = 1'b1;
                  miss_nx = miss_cnt_p1 + UC_W'(1);
                  if (miss_nx == UC_W'(UNLOCK_COUNT)) state_nx = HUNT;
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   // ---- stage p1: registered state and outputs ----
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_p1     <= HUNT;
         exp_p1       <= '0;
         match_cnt_p1 <= '0;
         miss_cnt_p1  <= '0;
         err_p1       <= 1'b0;
         sticky_p1    <= 1'b0;
         cnt_p1       <= '0;
         bits_p1      <= '0;
      end else begin
         state_p1     <= state_nx;
         exp_p1       <= exp_nx;
         match_cnt_p1 <= match_nx;
         miss_cnt_p1  <= miss_nx;
         err_p1       <= err_nx;
         bits_p1      <= err_nx ? err_inc_p0 : 5'd0;
         // Clear wins over a simultaneous error; the err_out pulse still fires
         if (clear_in) begin
            sticky_p1 <= 1'b0;
            cnt_p1    <= '0;
         end else if (err_nx) begin
            sticky_p1 <= 1'b1;
            cnt_p1    <= sat_add(cnt_p1, err_inc_p0);
         end
      end
   end

   assign locked_out     = (state_p1 == LOCKED);
   assign err_out        = err_p1;
   assign sticky_err_out = sticky_p1;
   assign err_count_out  = cnt_p1;

endmodule

// File: tb/tb_lfsr_16_checker.sv
// Bench for lfsr_16_checker: table of vectors plus hand sequences, expectations queued per word and checked one cycle later.
module tb_lfsr_16_checker;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        valid_a, clear_a, valid_b, clear_b;
   logic [15:0] data_a, data_b;
   logic        locked_a, err_a, sticky_a, locked_b, err_b, sticky_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
`ifdef LFSR_CHK_BITERR_EN
   logic [4:0]  bits_a, bits_b;
`endif

   always #5 clk_in = ~clk_in;

   lfsr_16_checker #(.LOCK_COUNT(8), .UNLOCK_COUNT(4), .ERR_W(16)) dut_a (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_a), .data_in(data_a),
      .clear_in(clear_a), .locked_out(locked_a), .err_out(err_a),
      .sticky_err_out(sticky_a), .err_count_out(cnt_a)
`ifdef LFSR_CHK_BITERR_EN
      , .err_bits_out(bits_a)
`endif
   );

   lfsr_16_checker #(.LOCK_COUNT(8), .UNLOCK_COUNT(4), .ERR_W(4)) dut_b (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_b), .data_in(data_b),
      .clear_in(clear_b), .locked_out(locked_b), .err_out(err_b),
      .sticky_err_out(sticky_b), .err_count_out(cnt_b)
`ifdef LFSR_CHK_BITERR_EN
      , .err_bits_out(bits_b)
`endif
   );

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        clr;
      logic        lock;
      logic        err;
      logic        sticky;
      logic [15:0] cnt;
      logic [4:0]  bits;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   step_no = 0;

   // Galois-style formulation of the generator: rotate left, fold taps when the MSB falls out
   function automatic logic [15:0] gen(input logic [15:0] q);
      return {q[14:0], q[15]} ^ (q[15] ? 16'h8004 : 16'h0000);
   endfunction

   function automatic int weight(input logic [15:0] got, input logic [15:0] truth);
`ifdef LFSR_CHK_BITERR_EN
      return $countones(got ^ truth);
`else
      return (got != truth) ? 1 : 0;
`endif
   endfunction

   function automatic vec_t mk(input logic v, input logic [15:0] d, input logic clr,
                               input logic lock, input logic err, input logic sticky,
                               input logic [15:0] cnt, input logic [4:0] bits);
      vec_t r;
      r.v = v; r.d = d; r.clr = clr; r.lock = lock;
      r.err = err; r.sticky = sticky; r.cnt = cnt; r.bits = bits;
      return r;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic step(input bit which, input vec_t r);
      vec_t e;
      int   lk, er, st, ct, bt;
      if (!which) begin
         valid_a = r.v; data_a = r.d; clear_a = r.clr;
         valid_b = 1'b0; clear_b = 1'b0;
      end else begin
         valid_b = r.v; data_b = r.d; clear_b = r.clr;
         valid_a = 1'b0; clear_a = 1'b0;
      end
      sb.push_back(r);
      @(posedge clk_in);
      #1;
      e = sb.pop_front();
      step_no++;
      bt = 0;
      if (!which) begin
         lk = int'(locked_a); er = int'(err_a); st = int'(sticky_a); ct = int'(cnt_a);
`ifdef LFSR_CHK_BITERR_EN
         bt = int'(bits_a);
`endif
      end else begin
         lk = int'(locked_b); er = int'(err_b); st = int'(sticky_b); ct = int'(cnt_b);
`ifdef LFSR_CHK_BITERR_EN
         bt = int'(bits_b);
`endif
      end
      chk($sformatf("locked[%0d]", step_no), lk, int'(e.lock));
      chk($sformatf("err[%0d]", step_no), er, int'(e.err));
      chk($sformatf("sticky[%0d]", step_no), st, int'(e.sticky));
      chk($sformatf("count[%0d]", step_no), ct, int'(e.cnt));
`ifdef LFSR_CHK_BITERR_EN
      chk($sformatf("bits[%0d]", step_no), bt, int'(e.bits));
`endif
   endtask

   initial begin
      logic [15:0] g, g4, w;
      int          cnt, wt;

      rst_n_in = 1'b0;
      valid_a = 1'b0; clear_a = 1'b0; data_a = '0;
      valid_b = 1'b0; clear_b = 1'b0; data_b = '0;

      // Vector table for dut_a: acquire, single error, clear, unlock, relock, valid gaps
      g = 16'h0001;
      for (int i = 1; i <= 20; i++) begin
         tbl.push_back(mk(1'b1, g, 1'b0, (i >= 9), 1'b0, 1'b0, 16'd0, 5'd0));
         g = gen(g);
      end
      w = g ^ 16'h0001;
      wt = weight(w, g);
      cnt = wt;
      tbl.push_back(mk(1'b1, w, 1'b0, 1'b1, 1'b1, 1'b1, 16'(cnt), 5'(wt)));
      g = gen(g);
      for (int i = 0; i < 5; i++) begin
         tbl.push_back(mk(1'b1, g, 1'b0, 1'b1, 1'b0, 1'b1, 16'(cnt), 5'd0));
         g = gen(g);
      end
      tbl.push_back(mk(1'b1, g, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 5'd0));
      g = gen(g);
      cnt = 0;
      for (int k = 1; k <= 4; k++) begin
         wt = weight(16'hFFFF, g);
         cnt += wt;
         tbl.push_back(mk(1'b1, 16'hFFFF, 1'b0, (k < 4), 1'b1, 1'b1, 16'(cnt), 5'(wt)));
         g = gen(g);
      end
      for (int j = 1; j <= 9; j++) begin
         tbl.push_back(mk(1'b1, g, 1'b0, (j >= 9), 1'b0, 1'b1, 16'(cnt), 5'd0));
         g = gen(g);
      end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b1, 16'(cnt), 5'd0));
         tbl.push_back(mk(1'b1, g, 1'b0, 1'b1, 1'b0, 1'b1, 16'(cnt), 5'd0));
         g = gen(g);
      end

      // Reset state
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_locked_a", int'(locked_a), 0);
      chk("rst_err_a", int'(err_a), 0);
      chk("rst_sticky_a", int'(sticky_a), 0);
      chk("rst_count_a", int'(cnt_a), 0);
      chk("rst_locked_b", int'(locked_b), 0);
      chk("rst_count_b", int'(cnt_b), 0);
      #3 rst_n_in = 1'b1;

      for (int i = 0; i < tbl.size(); i++) step(1'b0, tbl[i]);

      // dut_b: reseed on a bad word in VERIFY, lock, saturate the 4-bit counter, clear
      g4 = 16'hACE1;
      for (int j = 1; j <= 4; j++) begin
         step(1'b1, mk(1'b1, g4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 5'd0));
         g4 = gen(g4);
      end
      step(1'b1, mk(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 5'd0));
      g4 = gen(16'h1234);
      for (int j = 1; j <= 8; j++) begin
         step(1'b1, mk(1'b1, g4, 1'b0, (j >= 8), 1'b0, 1'b0, 16'd0, 5'd0));
         g4 = gen(g4);
      end
      cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         cnt = (cnt < 15) ? cnt + 1 : 15;
         step(1'b1, mk(1'b1, g4 ^ 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 16'(cnt), 5'd1));
         g4 = gen(g4);
         step(1'b1, mk(1'b1, g4, 1'b0, 1'b1, 1'b0, 1'b1, 16'(cnt), 5'd0));
         g4 = gen(g4);
      end
      step(1'b1, mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 5'd0));
      step(1'b1, mk(1'b1, g4 ^ 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 5'd1));
      g4 = gen(g4);
      step(1'b1, mk(1'b1, g4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 5'd0));

      // Asynchronous reset between clock edges while both checkers are locked
      valid_a = 1'b0; clear_a = 1'b0; valid_b = 1'b0; clear_b = 1'b0;
      @(posedge clk_in);
      #3 rst_n_in = 1'b0;
      #1;
      chk("async_locked_a", int'(locked_a), 0);
      chk("async_sticky_a", int'(sticky_a), 0);
      chk("async_count_a", int'(cnt_a), 0);
      chk("async_err_a", int'(err_a), 0);
      chk("async_locked_b", int'(locked_b), 0);
      #2 rst_n_in = 1'b1;

      // HUNT ignores zeros; 0x8000 seeds and 0x8005 is the first match
      for (int i = 0; i < 3; i++)
         step(1'b0, mk(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 5'd0));
      g = 16'h8000;
      for (int j = 1; j <= 9; j++) begin
         step(1'b0, mk(1'b1, g, 1'b0, (j >= 9), 1'b0, 1'b0, 16'd0, 5'd0));
         g = gen(g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
